sseg_mux_driver: RTL and testbench

Parametrised time-multiplexed 7-segment display driver for the Boolean board and derived boards. It scans any number of common-anode displays and digits from a prescaled clock, and adds 16-level PWM brightness, per-digit blanking and per-digit blinking. Segment data is snapshotted once per frame so the display never tears. It sits between the combinational BCD/hex-to-segment decoders and the board's anode and segment pins.

---
 rtl/sseg_pkg.sv | 13 +
 rtl/sseg_prescaler.sv | 27 ++
 rtl/sseg_mux_driver.sv | 160 ++++++++++++++++
 tb/tb_sseg_mux_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver
// and the board timing blocks built around it.
package sseg_pkg;

    localparam int SSEG_PHASES = 16;
    localparam logic [7:0] SSEG_OFF = 8'hFF;

    // Source cycles per PWM phase; one digit slot is SSEG_PHASES phases.
    function automatic int phase_cycles(input int clk_hz, input int digit_hz);
        return clk_hz / (digit_hz * SSEG_PHASES);
    endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Free-running divide-by-DIV counter with a one-cycle tick on the last count.
// Shared by the display scan and other board timing blocks.
module sseg_prescaler #(
    parameter int DIV = 1,
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver with PWM brightness,
// per-digit blanking/blinking and a once-per-frame input snapshot.
module sseg_mux_driver
    import sseg_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int NUM_DISPLAYS = 2,
    parameter int NUM_DIGITS   = 4,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_DISPLAYS*NUM_DIGITS*7-1:0] seg_in,
    input  logic [NUM_DISPLAYS*NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DISPLAYS*NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DISPLAYS*NUM_DIGITS-1:0]   blink_en,
    input  logic [3:0]                           brightness,
    output logic [NUM_DISPLAYS*NUM_DIGITS-1:0]   an,
    output logic [NUM_DISPLAYS*8-1:0]            seg,
    output logic                                 frame_start
);

    localparam int NK           = NUM_DISPLAYS * NUM_DIGITS;
    localparam int PHASE_CYCLES = phase_cycles(CLK_HZ, DIGIT_HZ);
    localparam int PRE_W        = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [3:0]       PHASE_LAST = 4'(SSEG_PHASES - 1);

    if (PHASE_CYCLES < 1) begin : g_bad_rate
        $error("sseg_mux_driver: CLK_HZ too low for DIGIT_HZ*16");
    end
    if (NUM_DIGITS < 2) begin : g_bad_digits
        $error("sseg_mux_driver: NUM_DIGITS must be at least 2");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("sseg_mux_driver: BLINK_FRAMES must be at least 1");
    end

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    sseg_prescaler #(
        .DIV (PHASE_CYCLES)
    ) u_pre (
        .clk   (clk),
        .reset (reset),
        .cnt   (pre_cnt),
        .tick  (tick)
    );

    logic [3:0]       phase;
    logic [IDX_W-1:0] idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_off;

    logic slot_end;
    logic frame_end;
    logic blink_end;
    logic fs;

    assign slot_end  = tick && (phase == PHASE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign blink_end = frame_end && (frame_cnt == FRM_LAST);
    assign fs        = (pre_cnt == '0) && (phase == '0) && (idx == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else begin
            if (tick) begin
                phase <= phase + 4'd1;
            end
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            if (frame_end) begin
                frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + FRM_W'(1);
            end
            if (blink_end) begin
                blink_off <= ~blink_off;
            end
        end
    end

    // Snapshot held for a whole frame so a digit never tears mid-scan.
    logic [6:0]            sh_seg   [NUM_DISPLAYS][NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sh_dp    [NUM_DISPLAYS];
    logic [NUM_DIGITS-1:0] sh_en    [NUM_DISPLAYS];
    logic [NUM_DIGITS-1:0] sh_blink [NUM_DISPLAYS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < NUM_DISPLAYS; d++) begin
                for (int p = 0; p < NUM_DIGITS; p++) begin
                    sh_seg[d][p] <= '1;
                end
                sh_dp[d]    <= '0;
                sh_en[d]    <= '0;
                sh_blink[d] <= '0;
            end
        end else if (fs) begin
            for (int d = 0; d < NUM_DISPLAYS; d++) begin
                for (int p = 0; p < NUM_DIGITS; p++) begin
                    sh_seg[d][p]   <= seg_in[7*(d*NUM_DIGITS+p) +: 7];
                    sh_dp[d][p]    <= dp_in[d*NUM_DIGITS+p];
                    sh_en[d][p]    <= digit_en[d*NUM_DIGITS+p];
                    sh_blink[d][p] <= blink_en[d*NUM_DIGITS+p];
                end
            end
        end
    end

    logic [NUM_DISPLAYS-1:0] lit;
    logic [NK-1:0]           an_nxt;
    logic [NUM_DISPLAYS*8-1:0] seg_nxt;

    always_comb begin
        lit = '0;
        for (int d = 0; d < NUM_DISPLAYS; d++) begin
            lit[d] = (phase <= brightness)
                  && sh_en[d][idx]
                  && !(blink_off && sh_blink[d][idx]);
        end
    end

    always_comb begin
        an_nxt  = '1;
        seg_nxt = '1;
        for (int d = 0; d < NUM_DISPLAYS; d++) begin
            for (int p = 0; p < NUM_DIGITS; p++) begin
                if (IDX_W'(p) == idx) begin
                    an_nxt[d*NUM_DIGITS+p] = ~lit[d];
                end
            end
            seg_nxt[8*d +: 8] = lit[d] ? {~sh_dp[d][idx], sh_seg[d][idx]}
                                       : SSEG_OFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an          <= '1;
            seg         <= '1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg         <= seg_nxt;
            frame_start <= fs;
        end
    end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Scoreboard bench: expected outputs derived from the edge count since reset.
// Monitor compares every cycle, decoupled from the stimulus driver.
module tb_sseg_mux_driver;

    localparam int ND    = 2;
    localparam int NG    = 4;
    localparam int NK    = ND * NG;
    localparam int BF    = 2;
    localparam int SLOT  = 16;
    localparam int FRAME = SLOT * NG;
    localparam int BLINK = FRAME * BF;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NK*7-1:0]   seg_in;
    logic [NK-1:0]     dp_in;
    logic [NK-1:0]     digit_en;
    logic [NK-1:0]     blink_en;
    logic [3:0]        brightness;
    logic [NK-1:0]     an;
    logic [ND*8-1:0]   seg;
    logic              frame_start;

    sseg_mux_driver #(
        .CLK_HZ       (1600),
        .DIGIT_HZ     (100),
        .NUM_DISPLAYS (ND),
        .NUM_DIGITS   (NG),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .blink_en    (blink_en),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NK-1:0]   an;
        logic [ND*8-1:0] seg;
        logic            fs;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   t = 0;

    logic [6:0] m_seg   [NK];
    logic       m_dp    [NK];
    logic       m_en    [NK];
    logic       m_blink [NK];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_seg[k]   = 7'h7F;
            m_dp[k]    = 1'b0;
            m_en[k]    = 1'b0;
            m_blink[k] = 1'b0;
        end
        t = 0;
    endtask

    task automatic model_snapshot();
        for (int k = 0; k < NK; k++) begin
            m_seg[k]   = seg_in[7*k +: 7];
            m_dp[k]    = dp_in[k];
            m_en[k]    = digit_en[k];
            m_blink[k] = blink_en[k];
        end
    endtask

    // Output after edge t shows the scan position reached after t-1 edges.
    function automatic exp_t predict();
        exp_t e;
        int s = t - 1;
        int ph = s % SLOT;
        int ix = (s / SLOT) % NG;
        bit boff = ((s / BLINK) % 2) == 1;
        e.an  = '1;
        e.seg = '1;
        e.fs  = (s % FRAME) == 0;
        for (int d = 0; d < ND; d++) begin
            int k = d * NG + ix;
            if (ph <= int'(brightness) && m_en[k] && !(boff && m_blink[k])) begin
                e.an[k] = 1'b0;
                e.seg[8*d +: 8] = {~m_dp[k], m_seg[k]};
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) begin
            t++;
            q.push_back(predict());
            if ((t - 1) % FRAME == 0) model_snapshot();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_an", 32'(an), 32'hFF);
        check("reset_seg", 32'(seg), 32'hFFFF);
        check("reset_fs", 32'(frame_start), 32'h0);
        q.delete();
        repeat (2) @(negedge clk);
        check("reset_hold_an", 32'(an), 32'hFF);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic randomize_inputs();
        seg_in     = {$urandom, $urandom};
        dp_in      = NK'($urandom);
        digit_en   = NK'($urandom);
        blink_en   = NK'($urandom);
        brightness = 4'($urandom_range(0, 15));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                check("an", 32'(an), 32'(e.an));
                check("seg", 32'(seg), 32'(e.seg));
                check("frame_start", 32'(frame_start), 32'(e.fs));
            end
        end
    end

    initial begin : driver
        for (int k = 0; k < NK; k++) seg_in[7*k +: 7] = 7'h40 | 7'(k);
        dp_in      = '0;
        digit_en   = '1;
        blink_en   = '0;
        brightness = 4'd15;
        model_reset();
        @(negedge clk);
        do_reset();

        // Full-brightness scan
        repeat (2 * FRAME) step();

        // PWM duty
        brightness = 4'd3;
        repeat (FRAME) step();
        brightness = 4'd0;
        repeat (FRAME) step();
        brightness = 4'd15;

        // Snapshot: change mid-frame
        while (t % FRAME != 20) step();
        seg_in = {$urandom, $urandom};
        repeat (FRAME + 8) step();

        // Blank and blink
        digit_en[5] = 1'b0;
        blink_en[0] = 1'b1;
        repeat (2 * BLINK + 8) step();

        // Decimal point
        dp_in[7] = 1'b1;
        repeat (2 * FRAME) step();

        // Random inputs changing at arbitrary cycles
        repeat (600) begin
            if ($urandom_range(0, 7) == 0) randomize_inputs();
            step();
        end

        // Reset mid-slot with a digit lit
        digit_en   = '1;
        blink_en   = '0;
        brightness = 4'd15;
        repeat (FRAME) step();
        while (t % FRAME != 37) step();
        do_reset();
        repeat (2 * FRAME) step();

        @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
